inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage of the single-cycle/pipelined MIPS core, directly upstream of the instruction ROM. Holds the program counter, drives the ROM address, captures the byte-corrected instruction word the ROM returns in the same cycle, and buffers `{pc, inst}` pairs in a small queue toward decode with a valid/ready handshake. Branch/jump redirects from downstream flush the queue and reload the PC; misaligned redirect targets raise a sticky fault.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `QUEUE_DEPTH`, 2, fetch queue entries; power of two, ≥2.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rom_addr`  out  32  current fetch PC, driven combinationally from the PC register.
- `rom_data`  in  32  instruction at `rom_addr`, valid in the same cycle (combinational ROM).
- `redirect_valid`  in  1  load new PC and flush this cycle.
- `redirect_pc`  in  32  redirect target.
- `out_valid`  out  1  head queue entry valid.
- `out_ready`  in  1  decode accepts head entry.
- `out_inst`  out  32  head instruction.
- `out_pc`  out  32  head instruction address.
- `out_pc_plus4`  out  32  `out_pc + 4`, combinational, modulo 2^32.
- `fetch_fault`  out  1  sticky misaligned-redirect flag.
- `fault_pc`  out  32  offending redirect target.

## Operation
- Reset values: PC = `RESET_PC`, queue count = 0, `out_valid` = 0, `out_inst`/`out_pc` = 0, `fetch_fault` = 0, `fault_pc` = 0.
- Fetch enable = `!redirect_valid && !fetch_fault && count < QUEUE_DEPTH` (count sampled at the start of the cycle). When enabled: push `{PC, rom_data}` and PC ← PC + 4. PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 0.
- Pop on `out_valid && out_ready`. Push and pop in the same cycle: count unchanged. Push is blocked while full, even if a pop occurs that cycle.
- Redirect, which has priority over everything except reset:
  - PC ← `redirect_pc`; all entries flushed; count ← 0; no push that cycle.
  - A handshake in the redirect cycle counts as delivered; remaining entries are discarded.
- Misaligned redirect (`redirect_pc[1:0] != 0`):
  - Flush as above; `fetch_fault` ← 1; `fault_pc` ← `redirect_pc`; fetching stops.
  - Cleared only by reset or a later aligned redirect, which clears the fault and resumes fetch at the new target.
- `out_inst`/`out_pc` hold their values while `out_valid && !out_ready`. They must not change until popped.

## Timing
- After reset deasserts: first push at the first rising edge. `out_valid` = 1 with `out_pc = RESET_PC` in the following cycle.
- Redirect sampled at edge k: the target is fetched and pushed at edge k+1, and is visible on the outputs after edge k+1. Redirect-to-output latency is 2 edges.
- With `out_ready` held high, throughput is one instruction per cycle and occupancy is 1.
- With `out_ready` low, the queue fills in `QUEUE_DEPTH` cycles, then the PC freezes and `rom_addr` is stable.
- Asynchronous reset mid-operation: all state returns to reset values immediately, regardless of any pending redirect or handshake.
- No combinational path from `out_ready` or `redirect_valid` to `out_valid`, `out_inst` or `out_pc`.

## Structure
- Shared package:
  - `INST_WIDTH` = 32.
  - Default `RESET_PC` constant.
  - Fetch-entry struct `{pc[31:0], inst[31:0]}`, reused by decode.
- One sub-module, `fetch_queue`:
  - Parameterized synchronous FIFO of fetch entries.
  - Provides push, pop, synchronous `flush`, `count`, and registered head outputs.
- The PC register, fetch-enable logic and fault logic live in the top level.

## Test plan
- Reset release, `out_ready` = 1, ROM words 0x11111111, 0x22222222, … → outputs show (pc 0x0, 0x11111111), (0x4, 0x22222222), … on consecutive cycles; `out_pc_plus4` = `out_pc + 4`.
- `out_ready` = 0 for 5 cycles, then 1 → `out_valid` after 1 cycle; `rom_addr` freezes at 0x8 with 2 entries held. Release delivers 0x0, 0x4, then 0x8 with no loss or duplicates.
- Redirect to 0x40 while the queue holds 2 entries and `out_ready` = 1 → only the head is delivered that cycle. The next valid output is pc 0x40, exactly 2 edges later.
- Redirect to 0x42 → `fetch_fault` = 1, `fault_pc` = 0x42, `out_valid` stays 0. A later redirect to 0x80 clears the fault and outputs pc 0x80.
- Redirect to 0xFFFF_FFFC → next outputs have pc 0xFFFF_FFFC then 0x0; `out_pc_plus4` = 0x0 for the first.
- Assert `reset` mid-stream, asynchronously between edges → `out_valid` = 0 and `rom_addr` = `RESET_PC` immediately. After release, the first output is pc `RESET_PC`.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared fetch types: instruction width, default reset PC and the {pc, inst} entry handed to decode.
package inst_fetch_pkg;

  localparam int          INST_WIDTH       = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]           pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  function automatic logic pc_aligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: ROM port, redirect request, decode handshake and fault status.
interface inst_fetch_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  modport master (
    output rom_addr, out_valid, out_inst, out_pc, out_pc_plus4, fetch_fault, fault_pc,
    input  rom_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  rom_addr, out_valid, out_inst, out_pc, out_pc_plus4, fetch_fault, fault_pc,
    output rom_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/inst_fetch_fetch_queue.sv
// Fetch-entry FIFO, one-cycle push-to-head latency; pushes are dropped while full, flush empties it.
// Head outputs and valid come straight from flops, so pop/flush never reach them combinationally.
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output logic         head_vld,
  output fetch_entry_t head_dat
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Fullness is judged on the start-of-cycle count, so a same-cycle pop never frees a slot.
    do_push  = push && (count_q != FULL);
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count    = count_q;
  assign head_vld = (count_q != '0);
  assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// MIPS fetch stage: PC register, ROM addressing and a fetch queue toward decode; push-to-output 1 edge.
// Fetch stalls while the queue is full or a fault is latched; a redirect flushes and reloads the PC.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  inst_fetch_if.master bus
);

  localparam int            CW   = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          fault_q, fault_d;
  logic [31:0]   fault_pc_q, fault_pc_d;
  logic          fetch_en;
  logic [CW-1:0] q_count;
  logic          head_vld;
  fetch_entry_t  head_dat;
  fetch_entry_t  push_dat;

  always_comb begin
    fetch_en   = !bus.redirect_valid && !fault_q && (q_count != FULL);
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      fault_d = !pc_aligned(bus.redirect_pc);
      if (!pc_aligned(bus.redirect_pc)) begin
        fault_pc_d = bus.redirect_pc;
      end
    end else if (fetch_en) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign push_dat = '{pc: pc_q, inst: bus.rom_data};

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clock    (clock),
    .reset    (reset),
    .push     (fetch_en),
    .push_dat (push_dat),
    .pop      (head_vld && bus.out_ready),
    .flush    (bus.redirect_valid),
    .count    (q_count),
    .head_vld (head_vld),
    .head_dat (head_dat)
  );

  assign bus.rom_addr     = pc_q;
  assign bus.out_valid    = head_vld;
  assign bus.out_inst     = head_dat.inst;
  assign bus.out_pc       = head_dat.pc;
  assign bus.out_pc_plus4 = head_dat.pc + 32'd4;
  assign bus.fetch_fault  = fault_q;
  assign bus.fault_pc     = fault_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand sequences and random traffic against a queue model.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          QUEUE_DEPTH = 2;

  logic clock;
  logic reset;
  inst_fetch_if bus ();

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of fetched PCs plus the architectural PC and fault state.
  logic [31:0] mq[$];
  logic [31:0] m_pc;
  bit          m_fault;
  logic [31:0] m_fpc;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a >> 2) + 32'd1;
    return idx * 32'h1111_1111;
  endfunction

  assign bus.rom_data = rom_fn(bus.rom_addr);

  inst_fetch #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(QUEUE_DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = RESET_PC;
    m_fault = 1'b0;
    m_fpc   = '0;
  endtask

  task automatic model_step(input bit rv, input logic [31:0] rp, input bit rdy);
    int occ;
    occ = mq.size();
    if (rv) begin
      mq.delete();
      m_pc = rp;
      if (rp[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_fpc   = rp;
      end else begin
        m_fault = 1'b0;
      end
    end else begin
      if (occ > 0 && rdy) void'(mq.pop_front());
      if (!m_fault && occ < QUEUE_DEPTH) begin
        mq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_model();
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
    chk("rom_addr", bus.rom_addr, m_pc);
    chk("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, m_fault});
    if (m_fault) chk("fault_pc", bus.fault_pc, m_fpc);
    if (mq.size() != 0) begin
      chk("out_pc", bus.out_pc, mq[0]);
      chk("out_inst", bus.out_inst, rom_fn(mq[0]));
      chk("out_pc_plus4", bus.out_pc_plus4, mq[0] + 32'd4);
    end
  endtask

  task automatic cycle(input bit rv, input logic [31:0] rp, input bit rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.out_ready      = rdy;
    @(posedge clock);
    model_step(rv, rp, rdy);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #3;
    reset = 1'b0;
  endtask

  typedef struct {
    bit          rv;
    logic [31:0] rp;
    bit          rdy;
    bit          ev;
    logic [31:0] epc;
    bit          ef;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0};
    vt[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b0};
    vt[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         1'b0};
    vt[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         1'b0};
    vt[4]  = '{1'b1, 32'h40,        1'b1, 1'b0, 32'h0,         1'b0};
    vt[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        1'b0};
    vt[6]  = '{1'b1, 32'h42,        1'b1, 1'b0, 32'h0,         1'b1};
    vt[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1};
    vt[8]  = '{1'b1, 32'h80,        1'b1, 1'b0, 32'h0,         1'b0};
    vt[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h80,        1'b0};
    vt[10] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         1'b0};
    vt[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0};
    vt[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0};

    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    model_reset();
    #2;
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset rom_addr", bus.rom_addr, RESET_PC);
    chk("reset out_pc", bus.out_pc, 32'd0);
    chk("reset out_inst", bus.out_inst, 32'd0);
    chk("reset fetch_fault", {31'd0, bus.fetch_fault}, 32'd0);
    chk("reset fault_pc", bus.fault_pc, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed table: streaming, stall, redirect, fault, wraparound.
    for (int i = 0; i < 13; i++) begin
      cycle(vt[i].rv, vt[i].rp, vt[i].rdy);
      chk($sformatf("vec%0d valid", i), {31'd0, bus.out_valid}, {31'd0, vt[i].ev});
      chk($sformatf("vec%0d fault", i), {31'd0, bus.fetch_fault}, {31'd0, vt[i].ef});
      if (vt[i].ev) chk($sformatf("vec%0d pc", i), bus.out_pc, vt[i].epc);
    end
    chk("fault_pc latched", bus.fault_pc, 32'h42);

    // Stall with out_ready low, then release: PC freezes at 0x8, no loss or duplication.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
    chk("stall rom_addr", bus.rom_addr, 32'h8);
    chk("stall head pc", bus.out_pc, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("release 1 pc", bus.out_pc, 32'h4);
    cycle(1'b0, 32'h0, 1'b1);
    chk("release 2 pc", bus.out_pc, 32'h8);
    cycle(1'b0, 32'h0, 1'b1);
    chk("release 3 pc", bus.out_pc, 32'hC);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit          rv;
      logic [31:0] rp;
      rv = ($urandom_range(0, 7) == 0);
      rp = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) rp[1:0] = 2'($urandom_range(1, 3));
      cycle(rv, rp, $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset between edges, with a redirect pending.
    cycle(1'b0, 32'h0, 1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #2;
    reset = 1'b1;
    #1;
    chk("async out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async rom_addr", bus.rom_addr, RESET_PC);
    chk("async fetch_fault", {31'd0, bus.fetch_fault}, 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    cycle(1'b0, 32'h0, 1'b1);
    chk("post-reset first pc", bus.out_pc, RESET_PC);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
